// File: rtl/dct_pkg.sv
// dct_pkg: shared types and constants for the 4x4 forward DCT datapath.
// Provides coefficient/vector typedefs, the transpose FSM state enum and a
// column write-bypass helper used by the transpose buffer.
package dct_pkg;

  localparam int unsigned DCT_N     = 4;
  localparam int unsigned DCT_W     = 10;
  localparam int unsigned DCT_IDX_W = 2;

  typedef logic signed [DCT_W-1:0]     dct_coef_t;
  typedef dct_coef_t [DCT_N-1:0]       dct_vec_t;
  typedef logic [DCT_IDX_W-1:0]        dct_idx_t;

  typedef enum logic {
    TR_FILL  = 1'b0,
    TR_DRAIN = 1'b1
  } tr_state_t;

  localparam dct_idx_t DCT_LAST_IDX = dct_idx_t'(DCT_N - 1);

  // Replace element wr_row of a bank column with the coefficient being
  // written this cycle, so a column can be registered in the same cycle the
  // row that completes it arrives.
  function automatic dct_vec_t dct_col_merge(input dct_vec_t  col,
                                             input logic      we,
                                             input dct_idx_t  wr_row,
                                             input dct_coef_t wr_coef);
    dct_vec_t res;
    res = col;
    if (we) res[wr_row] = wr_coef;
    return res;
  endfunction

endpackage

// File: rtl/dct_tr_bank.sv
// dct_tr_bank: N x N coefficient register array for the transpose buffer.
// Ports:
//   clk      - clock
//   we       - row write enable
//   wr_row   - row index written when we=1
//   wr_data  - row coefficients
//   rd_col   - column index for the combinational read
//   rd_data  - column rd_col; element i = row i
// Contents have no reset; they are always written before being read.
module dct_tr_bank
  import dct_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  dct_idx_t wr_row,
  input  dct_vec_t wr_data,
  input  dct_idx_t rd_col,
  output dct_vec_t rd_data
);

  dct_vec_t mem [DCT_N];

  // Row write
  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  // Column read
  always_comb begin
    for (int i = 0; i < DCT_N; i++) rd_data[i] = mem[i][rd_col];
  end

endmodule

// File: rtl/dct_transpose_4x4.sv
// dct_transpose_4x4: transpose buffer between the row and column passes of
// the 4x4 forward DCT. Takes one row per input handshake and emits one
// column per output handshake; all outputs are registered.
// Ports:
//   clk, rst (async, active high), clr (sync abort)
//   in_valid/in_ready/in_data    - row input, in_data[j] = coefficient j
//   out_valid/out_ready/out_data - column output, out_data[i] = row i
//   out_last                     - marks column 3 of a block
// Build option: DCT_TRANSPOSE_PINGPONG_EN selects a two-bank buffer that
// sustains one row in and one column out per cycle; otherwise a single
// bank alternates between FILL and DRAIN.
module dct_transpose_4x4
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = DCT_W,
  parameter int unsigned N      = DCT_N
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [N-1:0][DATA_W-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [N-1:0][DATA_W-1:0] out_data,
  output logic                           out_last
);

  dct_vec_t in_vec;
  logic     in_xfer;
  logic     out_xfer;
  dct_idx_t row_cnt;
  dct_idx_t col_cnt;
  dct_vec_t nxt_col;

  assign in_vec   = in_data;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef DCT_TRANSPOSE_PINGPONG_EN

  logic       wr_bank, wr_bank_nxt;
  logic       rd_bank, nb;
  logic       fill_done, free, load, avail;
  logic [1:0] full, full_nxt, we_b;
  dct_idx_t   nc;
  dct_vec_t   rd_data [2];

  assign fill_done   = in_xfer && (row_cnt == DCT_LAST_IDX);
  assign free        = out_xfer && (col_cnt == DCT_LAST_IDX);
  assign load        = !out_valid || out_xfer;
  assign wr_bank_nxt = fill_done ? ~wr_bank : wr_bank;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    assign we_b[k] = in_xfer && !clr && (wr_bank == 1'(k));
    dct_tr_bank u_bank (
      .clk     (clk),
      .we      (we_b[k]),
      .wr_row  (row_cnt),
      .wr_data (in_vec),
      .rd_col  (nc),
      .rd_data (rd_data[k])
    );
  end

  // Next column to present: continue the current bank, or move to the other
  // bank (in fill order) once the current one is freed.
  always_comb begin
    full_nxt = full;
    if (fill_done) full_nxt[wr_bank] = 1'b1;
    if (free)      full_nxt[rd_bank] = 1'b0;
    nb = rd_bank;
    nc = '0;
    if (out_valid && !free) begin
      nc = dct_idx_t'(col_cnt + 1'b1);
    end else if (free) begin
      nb = ~rd_bank;
    end
    avail = (out_valid && !free) ? 1'b1 : full_nxt[nb];
  end

  assign nxt_col = dct_col_merge(rd_data[nb], we_b[nb], row_cnt, in_vec[nc]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      in_ready <= !full_nxt[wr_bank_nxt];
      if (in_xfer) row_cnt <= dct_idx_t'(row_cnt + 1'b1);
      if (load) begin
        rd_bank   <= nb;
        col_cnt   <= nc;
        out_valid <= avail;
        out_last  <= avail && (nc == DCT_LAST_IDX);
        out_data  <= avail ? nxt_col : '0;
      end
    end
  end

`else

  tr_state_t state;
  logic      we;
  dct_idx_t  rd_col;
  dct_vec_t  rd_data;

  assign we     = in_xfer && !clr;
  // Column 0 is loaded on the 4th row; later columns on each output transfer.
  assign rd_col = (state == TR_FILL) ? '0 : dct_idx_t'(col_cnt + 1'b1);

  dct_tr_bank u_bank (
    .clk     (clk),
    .we      (we),
    .wr_row  (row_cnt),
    .wr_data (in_vec),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  assign nxt_col = dct_col_merge(rd_data, we, row_cnt, in_vec[rd_col]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TR_FILL;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= TR_FILL;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        TR_FILL: begin
          if (in_xfer) begin
            row_cnt <= dct_idx_t'(row_cnt + 1'b1);
            if (row_cnt == DCT_LAST_IDX) begin
              state     <= TR_DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_data  <= nxt_col;
            end
          end
        end
        TR_DRAIN: begin
          if (out_xfer) begin
            col_cnt <= dct_idx_t'(col_cnt + 1'b1);
            if (col_cnt == DCT_LAST_IDX) begin
              state     <= TR_FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              out_last <= (rd_col == DCT_LAST_IDX);
              out_data <= nxt_col;
            end
          end
        end
        default: state <= TR_FILL;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_dct_transpose_4x4.sv
// tb_dct_transpose_4x4: scoreboard bench for the single-bank transpose
// buffer. Expected columns are queued when the 4th row of a block is
// accepted and compared as the DUT presents them.
`timescale 1ns/1ps
module tb_dct_transpose_4x4;
  import dct_pkg::*;

  typedef struct packed {
    dct_vec_t data;
    logic     last;
  } col_t;

  logic     clk = 1'b0;
  logic     rst, clr, in_valid, in_ready, out_valid, out_ready, out_last;
  dct_vec_t in_data, out_data;

  int       n_checks = 0;
  int       n_pass   = 0;
  col_t     exp_q [$];
  dct_vec_t rows [4];
  dct_vec_t blk [4];
  dct_vec_t prev_data;
  int       row_idx      = 0;
  int       n_pop        = 0;
  int       ready_mode   = 0;
  bit       expect_first = 1'b0;
  bit       prev_stall   = 1'b0;

  always #5 clk = ~clk;

  dct_transpose_4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, other stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      row_idx      = 0;
      expect_first = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (expect_first) begin
        check("first_valid_latency", out_valid, 1);
        expect_first = 1'b0;
      end
      check("in_ready_vs_state", in_ready, !out_valid);
      if (out_valid) begin
        if (prev_stall) check("stall_stable", out_data, prev_data);
        if (exp_q.size() == 0) begin
          check("spurious_column", out_valid, 0);
        end else begin
          check("col_data", out_data, exp_q[0].data);
          check("col_last", out_last, exp_q[0].last);
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
      end else begin
        check("idle_data_zero", out_data, 0);
        check("idle_last_zero", out_last, 0);
        prev_stall = 1'b0;
      end
      if (clr) begin
        exp_q.delete();
        row_idx    = 0;
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
        if (in_valid && in_ready) begin
          rows[row_idx] = in_data;
          if (row_idx == 3) begin
            for (int j = 0; j < 4; j++) begin
              col_t c;
              for (int i = 0; i < 4; i++) c.data[i] = rows[i][j];
              c.last = (j == 3);
              exp_q.push_back(c);
            end
            expect_first = 1'b1;
            row_idx      = 0;
          end else begin
            row_idx++;
          end
        end
      end
    end
  end

  // Called aligned to posedge+1; returns aligned to posedge+1
  task automatic send_row(input dct_vec_t r, input int max_gap);
    int gap;
    int t;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    t   = 0;
    acc = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = r;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("row_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_block(input int max_gap);
    for (int r = 0; r < 4; r++) send_row(blk[r], max_gap);
  endtask

  task automatic rand_block();
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) blk[r][j] = dct_coef_t'($urandom_range(0, 1023));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int p0;
    int t;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);

    // Counting pattern, full-rate downstream
    ready_mode = 0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) blk[r][j] = dct_coef_t'(r * 4 + j + 1);
    p0 = n_pop;
    send_block(0);
    wait_drain();
    check("count_cols", n_pop - p0, 4);

    // Signed extremes alternating
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        blk[r][j] = ((r + j) % 2 == 1) ? dct_coef_t'(511) : dct_coef_t'(-512);
    p0 = n_pop;
    send_block(0);
    wait_drain();
    check("extreme_cols", n_pop - p0, 4);

    // Back-pressure toggling with random input gaps
    ready_mode = 1;
    p0 = n_pop;
    for (int b = 0; b < 3; b++) begin
      rand_block();
      send_block(3);
    end
    wait_drain();
    check("backpressure_cols", n_pop - p0, 12);

    // Random ready, random gaps
    ready_mode = 2;
    p0 = n_pop;
    for (int b = 0; b < 3; b++) begin
      rand_block();
      send_block(2);
    end
    wait_drain();
    check("random_ready_cols", n_pop - p0, 12);

    // clr after 2 rows, coincident with a row offer that must be dropped
    ready_mode = 0;
    rand_block();
    send_row(blk[0], 0);
    send_row(blk[1], 0);
    clr = 1'b1; in_valid = 1'b1; in_data = blk[2];
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    p0 = n_pop;
    rand_block();
    send_block(1);
    wait_drain();
    check("clr_fill_cols", n_pop - p0, 4);

    // clr during DRAIN drops the pending block
    ready_mode = 3;
    rand_block();
    send_block(0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_drain_out_valid", out_valid, 0);
    check("clr_drain_in_ready", in_ready, 1);
    ready_mode = 0;
    p0 = n_pop;
    rand_block();
    send_block(0);
    wait_drain();
    check("clr_drain_next_cols", n_pop - p0, 4);

    // Async reset after column 1 of a block
    ready_mode = 1;
    rand_block();
    p0 = n_pop;
    send_block(0);
    t = 0;
    while (n_pop < p0 + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("rst_wait_timeout", 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    ready_mode = 0;
    p0 = n_pop;
    rand_block();
    send_block(0);
    wait_drain();
    check("rst_next_cols", n_pop - p0, 4);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
